// File: rtl/tcpc_reg_arbiter.sv
// Arbitrates host (I2C) and internal status-logic accesses onto a single-port TCPC register file.
// Host writes to the ALERT range are write-1-to-clear and internal requests set bits; both are done as atomic read-modify-writes.
module tcpc_reg_arbiter #(
    parameter logic [7:0] W1C_BASE = 8'h10,
    parameter int         W1C_NUM  = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       H_REQ,
    input  logic       H_WR,
    input  logic [7:0] H_ADDR,
    input  logic [7:0] H_WDATA,
    output logic       H_ACK,
    output logic [7:0] H_RDATA,
    input  logic       I_REQ,
    input  logic [7:0] I_ADDR,
    input  logic [7:0] I_SET,
    output logic       I_ACK,
    output logic       RF_EN,
    output logic       RF_WR,
    output logic [7:0] RF_ADDR,
    output logic [7:0] RF_WDATA,
    input  logic [7:0] RF_RDATA,
    output logic       BUSY
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        WB   = 3'd3,
        ACK  = 3'd4
    } state_t;

    // A 9-bit compare keeps a range that ends at 0xFF from wrapping.
    function automatic logic in_w1c(input logic [7:0] addr);
        logic [8:0] lo;
        logic [8:0] hi;
        lo = {1'b0, W1C_BASE};
        hi = lo + 9'(W1C_NUM);
        return ({1'b0, addr} >= lo) && ({1'b0, addr} < hi);
    endfunction

    state_t     state_q,      state_d;
    logic       last_int_q,   last_int_d;
    logic       gnt_int_q,    gnt_int_d;
    logic       rmw_q,        rmw_d;
    logic [7:0] addr_q,       addr_d;
    logic [7:0] data_q,       data_d;
    logic       h_ack_q,      h_ack_d;
    logic [7:0] h_rdata_q,    h_rdata_d;
    logic       i_ack_q,      i_ack_d;
    logic       rf_en_q,      rf_en_d;
    logic       rf_wr_q,      rf_wr_d;
    logic [7:0] rf_addr_q,    rf_addr_d;
    logic [7:0] rf_wdata_q,   rf_wdata_d;
    logic       busy_q,       busy_d;

    // Next-state, arbitration and next-output logic; outputs are computed for the state being entered.
    always_comb begin
        state_d    = state_q;
        last_int_d = last_int_q;
        gnt_int_d  = gnt_int_q;
        rmw_d      = rmw_q;
        addr_d     = addr_q;
        data_d     = data_q;
        h_ack_d    = 1'b0;
        h_rdata_d  = 8'h00;
        i_ack_d    = 1'b0;
        rf_en_d    = 1'b0;
        rf_wr_d    = 1'b0;
        rf_addr_d  = 8'h00;
        rf_wdata_d = 8'h00;

        case (state_q)
            IDLE: begin
                if (H_REQ && (!I_REQ || last_int_q)) begin
                    gnt_int_d  = 1'b0;
                    last_int_d = 1'b0;
                    addr_d     = H_ADDR;
                    data_d     = H_WDATA;
                    rf_en_d    = 1'b1;
                    rf_addr_d  = H_ADDR;
                    if (H_WR && !in_w1c(H_ADDR)) begin
                        state_d    = WR;
                        rmw_d      = 1'b0;
                        rf_wr_d    = 1'b1;
                        rf_wdata_d = H_WDATA;
                    end else begin
                        state_d = RD;
                        rmw_d   = H_WR;
                    end
                end else if (I_REQ) begin
                    gnt_int_d  = 1'b1;
                    last_int_d = 1'b1;
                    addr_d     = I_ADDR;
                    data_d     = I_SET;
                    rmw_d      = 1'b1;
                    state_d    = RD;
                    rf_en_d    = 1'b1;
                    rf_addr_d  = I_ADDR;
                end else begin
                    state_d = IDLE;
                end
            end
            RD: begin
                if (rmw_q) begin
                    state_d   = WB;
                    rf_en_d   = 1'b1;
                    rf_wr_d   = 1'b1;
                    rf_addr_d = addr_q;
                    if (gnt_int_q) begin
                        rf_wdata_d = RF_RDATA | data_q;
                    end else begin
                        rf_wdata_d = RF_RDATA & ~data_q;
                    end
                end else begin
                    state_d   = ACK;
                    h_ack_d   = ~gnt_int_q;
                    i_ack_d   = gnt_int_q;
                    h_rdata_d = RF_RDATA;
                end
            end
            WR, WB: begin
                state_d = ACK;
                h_ack_d = ~gnt_int_q;
                i_ack_d = gnt_int_q;
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset leaves "internal" as last grant so the host wins the first tie.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            last_int_q <= 1'b1;
            gnt_int_q  <= 1'b0;
            rmw_q      <= 1'b0;
            addr_q     <= 8'h00;
            data_q     <= 8'h00;
            h_ack_q    <= 1'b0;
            h_rdata_q  <= 8'h00;
            i_ack_q    <= 1'b0;
            rf_en_q    <= 1'b0;
            rf_wr_q    <= 1'b0;
            rf_addr_q  <= 8'h00;
            rf_wdata_q <= 8'h00;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_int_q <= last_int_d;
            gnt_int_q  <= gnt_int_d;
            rmw_q      <= rmw_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            h_ack_q    <= h_ack_d;
            h_rdata_q  <= h_rdata_d;
            i_ack_q    <= i_ack_d;
            rf_en_q    <= rf_en_d;
            rf_wr_q    <= rf_wr_d;
            rf_addr_q  <= rf_addr_d;
            rf_wdata_q <= rf_wdata_d;
            busy_q     <= busy_d;
        end
    end

    assign H_ACK    = h_ack_q;
    assign H_RDATA  = h_rdata_q;
    assign I_ACK    = i_ack_q;
    assign RF_EN    = rf_en_q;
    assign RF_WR    = rf_wr_q;
    assign RF_ADDR  = rf_addr_q;
    assign RF_WDATA = rf_wdata_q;
    assign BUSY     = busy_q;

endmodule

// File: tb/tb_tcpc_reg_arbiter.sv
// Directed, table-driven bench for tcpc_reg_arbiter with a behavioural register file.
// Hand sequences cover round-robin ties and reset in the middle of a read-modify-write.
module tb_tcpc_reg_arbiter;

    logic       CLK;
    logic       RESET;
    logic       H_REQ;
    logic       H_WR;
    logic [7:0] H_ADDR;
    logic [7:0] H_WDATA;
    logic       H_ACK;
    logic [7:0] H_RDATA;
    logic       I_REQ;
    logic [7:0] I_ADDR;
    logic [7:0] I_SET;
    logic       I_ACK;
    logic       RF_EN;
    logic       RF_WR;
    logic [7:0] RF_ADDR;
    logic [7:0] RF_WDATA;
    logic [7:0] RF_RDATA;
    logic       BUSY;

    int total = 0;
    int bad   = 0;

    tcpc_reg_arbiter #(.W1C_BASE(8'h10), .W1C_NUM(2)) dut (
        .CLK(CLK), .RESET(RESET),
        .H_REQ(H_REQ), .H_WR(H_WR), .H_ADDR(H_ADDR), .H_WDATA(H_WDATA),
        .H_ACK(H_ACK), .H_RDATA(H_RDATA),
        .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_SET(I_SET), .I_ACK(I_ACK),
        .RF_EN(RF_EN), .RF_WR(RF_WR), .RF_ADDR(RF_ADDR), .RF_WDATA(RF_WDATA),
        .RF_RDATA(RF_RDATA), .BUSY(BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Register file: read data follows the address combinationally, writes land on the clock edge.
    logic [7:0] mem [0:255];
    logic       pre_we;
    logic [7:0] pre_addr;
    logic [7:0] pre_data;
    assign RF_RDATA = mem[RF_ADDR];
    always @(posedge CLK) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (RF_EN && RF_WR) mem[RF_ADDR] <= RF_WDATA;
    end

    typedef struct {
        logic       is_int;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] pre;
        int         lat;
        int         wcnt;
        int         rcnt;
        logic [7:0] wdata;
        logic [7:0] rdata;
        logic [7:0] mem_after;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int hacks = 0, iacks = 0, wcnt = 0, rcnt = 0, ackcyc = 0, idle_cyc = 0, zv = 0;
        logic [7:0] wd = 8'h00;
        logic [7:0] rd = 8'h00;
        @(negedge CLK);
        pre_we = 1'b1; pre_addr = v.addr; pre_data = v.pre;
        if (v.is_int) begin
            I_REQ = 1'b1; I_ADDR = v.addr; I_SET = v.data;
        end else begin
            H_REQ = 1'b1; H_WR = v.wr; H_ADDR = v.addr; H_WDATA = v.data;
        end
        for (int c = 1; c <= 12; c++) begin
            @(negedge CLK);
            pre_we = 1'b0;
            if (RF_EN && RF_WR) begin wcnt++; wd = RF_WDATA; end
            if (RF_EN && !RF_WR) rcnt++;
            if (!RF_EN && (RF_ADDR != 8'h00 || RF_WDATA != 8'h00)) zv++;
            if (H_ACK) begin hacks++; ackcyc = c; rd = H_RDATA; end
            if (I_ACK) begin iacks++; ackcyc = c; end
            if (H_ACK || I_ACK) begin H_REQ = 1'b0; I_REQ = 1'b0; end
            if (!BUSY && idle_cyc == 0 && c > 1) idle_cyc = c;
        end
        check({tag, "_ack_lat"},   ackcyc, v.lat);
        check({tag, "_own_acks"},  v.is_int ? iacks : hacks, 1);
        check({tag, "_other_acks"}, v.is_int ? hacks : iacks, 0);
        check({tag, "_wr_strobes"}, wcnt, v.wcnt);
        check({tag, "_rd_strobes"}, rcnt, v.rcnt);
        check({tag, "_wdata"},     wd, v.wdata);
        check({tag, "_rdata"},     rd, v.rdata);
        check({tag, "_busy_low"},  idle_cyc, v.lat + 1);
        check({tag, "_mem"},       mem[v.addr], v.mem_after);
        check({tag, "_idle_zero"}, zv, 0);
    endtask

    task automatic do_reset(input int n);
        @(negedge CLK);
        RESET = 1'b1; H_REQ = 1'b0; I_REQ = 1'b0;
        repeat (n) @(negedge CLK);
        RESET = 1'b0;
    endtask

    initial begin
        int order [4];
        int nacks;
        int viol;
        logic       pend_rd;
        logic [7:0] pend_addr;

        RESET = 1'b1; H_REQ = 1'b0; H_WR = 1'b0; H_ADDR = 8'h00; H_WDATA = 8'h00;
        I_REQ = 1'b0; I_ADDR = 8'h00; I_SET = 8'h00;
        pre_we = 1'b0; pre_addr = 8'h00; pre_data = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        //            int   wr    addr   data   pre    lat wc rc wdata  rdata  mem
        vecs[0] = '{1'b0, 1'b1, 8'h1A, 8'h63, 8'h00, 2, 1, 0, 8'h63, 8'h00, 8'h63};
        vecs[1] = '{1'b0, 1'b0, 8'h1B, 8'h00, 8'h91, 2, 0, 1, 8'h00, 8'h91, 8'h91};
        vecs[2] = '{1'b0, 1'b1, 8'h10, 8'h24, 8'h36, 3, 1, 1, 8'h12, 8'h00, 8'h12};
        vecs[3] = '{1'b1, 1'b0, 8'h10, 8'h41, 8'h12, 3, 1, 1, 8'h53, 8'h00, 8'h53};
        vecs[4] = '{1'b0, 1'b1, 8'h11, 8'h00, 8'hA5, 3, 1, 1, 8'hA5, 8'h00, 8'hA5};
        vecs[5] = '{1'b1, 1'b0, 8'h20, 8'h00, 8'h0F, 3, 1, 1, 8'h0F, 8'h00, 8'h0F};
        vecs[6] = '{1'b0, 1'b1, 8'h12, 8'h0C, 8'hFF, 2, 1, 0, 8'h0C, 8'h00, 8'h0C};
        vecs[7] = '{1'b0, 1'b1, 8'h0F, 8'h01, 8'h77, 2, 1, 0, 8'h01, 8'h00, 8'h01};
        vecs[8] = '{1'b0, 1'b0, 8'h10, 8'hFF, 8'h5A, 2, 0, 1, 8'h00, 8'h5A, 8'h5A};
        vecs[9] = '{1'b1, 1'b0, 8'hFF, 8'h01, 8'h80, 3, 1, 1, 8'h81, 8'h00, 8'h81};

        repeat (3) @(negedge CLK);
        check("reset_outputs", {H_ACK, H_RDATA, I_ACK, RF_EN, RF_WR, RF_ADDR, RF_WDATA, BUSY}, 32'h0);
        RESET = 1'b0;

        for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Both requesters held high: host first after reset, then strict alternation.
        @(negedge CLK);
        RESET = 1'b1; pre_we = 1'b1; pre_addr = 8'h10; pre_data = 8'hFF;
        @(negedge CLK);
        pre_addr = 8'h11; pre_data = 8'h00;
        @(negedge CLK);
        pre_we = 1'b0; RESET = 1'b0;
        H_REQ = 1'b1; H_WR = 1'b1; H_ADDR = 8'h10; H_WDATA = 8'h01;
        I_REQ = 1'b1; I_ADDR = 8'h11; I_SET = 8'h02;
        nacks = 0; viol = 0; pend_rd = 1'b0; pend_addr = 8'h00;
        for (int i = 0; i < 4; i++) order[i] = 0;
        for (int c = 0; c < 40 && nacks < 4; c++) begin
            @(negedge CLK);
            if (pend_rd && !(RF_EN && RF_WR && RF_ADDR == pend_addr)) viol++;
            pend_rd = RF_EN && !RF_WR;
            pend_addr = RF_ADDR;
            if (H_ACK && I_ACK) viol++;
            if (H_ACK) begin order[nacks] = 1; nacks++; end
            else if (I_ACK) begin order[nacks] = 2; nacks++; end
        end
        H_REQ = 1'b0; I_REQ = 1'b0;
        check("rr_ack_count", nacks, 4);
        check("rr_grant0_host", order[0], 1);
        check("rr_grant1_int",  order[1], 2);
        check("rr_grant2_host", order[2], 1);
        check("rr_grant3_int",  order[3], 2);
        check("rr_no_interleave", viol, 0);
        repeat (3) @(negedge CLK);
        check("rr_mem10", mem[8'h10], 8'hFE);
        check("rr_mem11", mem[8'h11], 8'h02);

        // Reset lands right after the read strobe of a W1C sequence.
        do_reset(2);
        @(negedge CLK);
        pre_we = 1'b1; pre_addr = 8'h10; pre_data = 8'h36;
        H_REQ = 1'b1; H_WR = 1'b1; H_ADDR = 8'h10; H_WDATA = 8'h24;
        @(negedge CLK);
        pre_we = 1'b0;
        check("mid_rd_strobe", {RF_EN, RF_WR, RF_ADDR}, {2'b10, 8'h10});
        RESET = 1'b1; H_REQ = 1'b0;
        @(negedge CLK);
        check("mid_reset_outputs", {H_ACK, H_RDATA, I_ACK, RF_EN, RF_WR, RF_ADDR, RF_WDATA, BUSY}, 32'h0);
        RESET = 1'b0;
        viol = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            if (H_ACK || I_ACK || RF_EN || BUSY) viol++;
        end
        check("mid_reset_quiet", viol, 0);
        check("mid_reset_mem", mem[8'h10], 8'h36);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
